reset_sequencer_n: RTL and testbench

//  Board-level reset sequencer for the de10_nano golden design, sitting between FPGA_CLK1_50 and all user logic.

---
 rtl/reset_sequencer_n_pkg.sv | 12 +
 rtl/reset_sequencer_n_sync_2ff.sv | 28 ++
 rtl/reset_sequencer_n.sv | 155 +++++++++++++++
 tb/tb_reset_sequencer_n.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_n_pkg.sv
// Shared state encodings for the board-level reset sequencer.
// The encodings are plain localparams so legacy tools and debug scripts can decode seq_state directly.
package rst_seq_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [STATE_W-1:0] ST_HOLD      = 2'd1;
  localparam logic [STATE_W-1:0] ST_RELEASE   = 2'd2;
  localparam logic [STATE_W-1:0] ST_RUN       = 2'd3;

endpackage

// File: rtl/reset_sequencer_n_sync_2ff.sv
// Generic two-flop synchroniser for slow level signals crossing into clk.
// Both stages clear to 0 on the synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments let both stages sample the old values, so this stays a two-stage shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer_n.sv
// Multi-channel reset sequencer: filtered PLL lock, fixed hold, then in-order channel release.
// The sequencer restarts on lock loss (back to WAIT_LOCK) or on a soft request (back to HOLD).
module reset_sequencer_n
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 100,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               soft_req,
  output logic [NUM_CH-1:0]  rst_ch,
  output logic               all_released,
  output logic [STATE_W-1:0] seq_state
);

  localparam int IDX_W = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

  logic                locked_s;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_CH-1:0]   rst_ch_q, rst_ch_d;
  logic                all_released_q, all_released_d;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    // NOTE: every next-state signal takes its current value first, so no path through the logic infers a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    rst_ch_d       = rst_ch_q;
    all_released_d = all_released_q;

    if (state_q != ST_WAIT_LOCK && !locked_s) begin
      // Lock loss outranks a simultaneous soft request.
      state_d        = ST_WAIT_LOCK;
      cnt_d          = '0;
      idx_d          = '0;
      rst_ch_d       = '1;
      all_released_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          rst_ch_d       = '1;
          all_released_d = 1'b0;
          if (!locked_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_HOLD: begin
          if (soft_req) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            cnt_d       = '0;
            rst_ch_d[0] = 1'b0;
            if (NUM_CH == 1) begin
              state_d        = ST_RUN;
              all_released_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (soft_req) begin
            state_d        = ST_HOLD;
            cnt_d          = '0;
            idx_d          = '0;
            rst_ch_d       = '1;
            all_released_d = 1'b0;
          end else if (cnt_q == GAP_LAST) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (IDX_W'(i) == idx_q) rst_ch_d[i] = 1'b0;
            end
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_d        = ST_RUN;
              all_released_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RUN: begin
          if (soft_req) begin
            state_d        = ST_HOLD;
            cnt_d          = '0;
            idx_d          = '0;
            rst_ch_d       = '1;
            all_released_d = 1'b0;
          end
        end

        default: begin
          state_d        = ST_WAIT_LOCK;
          cnt_d          = '0;
          idx_d          = '0;
          rst_ch_d       = '1;
          all_released_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_WAIT_LOCK;
      cnt_q          <= '0;
      idx_q          <= '0;
      rst_ch_q       <= '1;
      all_released_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      rst_ch_q       <= rst_ch_d;
      all_released_q <= all_released_d;
    end
  end

  assign rst_ch       = rst_ch_q;
  assign all_released = all_released_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_reset_sequencer_n.sv
// Scoreboard bench: stimulus pushes expected output transitions (edge number + values),
// a negedge monitor pops one entry whenever either DUT's outputs change.
module tb_reset_sequencer_n;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       rel;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Default-parameter instance.
  logic       a_reset, a_pll, a_soft;
  logic [3:0] a_rst_ch;
  logic       a_all;
  logic [1:0] a_state;

  reset_sequencer_n u_dut_a (
    .clk          (clk),
    .reset        (a_reset),
    .pll_locked   (a_pll),
    .soft_req     (a_soft),
    .rst_ch       (a_rst_ch),
    .all_released (a_all),
    .seq_state    (a_state)
  );

  // Single-channel, minimum-timing instance.
  logic       b_reset, b_pll, b_soft;
  logic [0:0] b_rst_ch;
  logic       b_all;
  logic [1:0] b_state;

  reset_sequencer_n #(
    .NUM_CH      (1),
    .LOCK_FILTER (8),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (1),
    .CNT_W       (16)
  ) u_dut_b (
    .clk          (clk),
    .reset        (b_reset),
    .pll_locked   (b_pll),
    .soft_req     (b_soft),
    .rst_ch       (b_rst_ch),
    .all_released (b_all),
    .seq_state    (b_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  // Starting values are impossible output combinations, so the first real value always registers as a change.
  logic [6:0] prev_a = 7'h7f;
  logic [3:0] prev_b = 4'hf;
  logic [6:0] cur_a;
  logic [3:0] cur_b;
  exp_t       e;

  always @(negedge clk) begin
    cur_a = {a_rst_ch, a_all, a_state};
    if (cur_a !== prev_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_change", 32'(cur_a), 32'(prev_a));
      end else begin
        e = qa.pop_front();
        check("a_edge", cyc, e.cyc);
        check("a_rst_ch", 32'(a_rst_ch), 32'(e.rst));
        check("a_all_released", 32'(a_all), 32'(e.rel));
        check("a_seq_state", 32'(a_state), 32'(e.st));
      end
    end
    prev_a = cur_a;

    cur_b = {b_rst_ch, b_all, b_state};
    if (cur_b !== prev_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_change", 32'(cur_b), 32'(prev_b));
      end else begin
        e = qb.pop_front();
        check("b_edge", cyc, e.cyc);
        check("b_rst_ch", 32'(b_rst_ch), 32'(e.rst));
        check("b_all_released", 32'(b_all), 32'(e.rel));
        check("b_seq_state", 32'(b_state), 32'(e.st));
      end
    end
    prev_b = cur_b;
  end

  // Returns 1 time unit after posedge number n.
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input int c, input logic [3:0] r, input logic l, input logic [1:0] s);
    exp_t x;
    x.cyc = c; x.rst = r; x.rel = l; x.st = s;
    qa.push_back(x);
  endtask

  task automatic push_b(input int c, input logic r, input logic l, input logic [1:0] s);
    exp_t x;
    x.cyc = c; x.rst = {3'b000, r}; x.rel = l; x.st = s;
    qb.push_back(x);
  endtask

  // Default sequence, base = last edge before pll_locked is first captured as 1:
  // 2 sync + 8 filter -> HOLD at +10, 100 hold -> ch0 at +110, then every 16 cycles.
  task automatic push_seq(input int base, input int first, input int last);
    int         offs[5] = '{10, 110, 126, 142, 158};
    logic [3:0] rs[5]   = '{4'hf, 4'he, 4'hc, 4'h8, 4'h0};
    logic       ls[5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] ss[5]   = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
    for (int i = first; i <= last; i++) push_a(base + offs[i], rs[i], ls[i], ss[i]);
  endtask

  initial begin
    a_reset = 1'b1; a_pll = 1'b1; a_soft = 1'b0;
    b_reset = 1'b1; b_pll = 1'b1; b_soft = 1'b0;
    push_a(1, 4'hf, 1'b0, 2'd0);
    push_b(1, 1'b1, 1'b0, 2'd0);

    // Lock present throughout: full bring-up.
    wait_edge(2);   a_reset = 1'b0; push_seq(2, 0, 4);

    // Lock loss in RUN, then relock.
    wait_edge(165); a_pll = 1'b0; push_a(168, 4'hf, 1'b0, 2'd0);
    wait_edge(170); a_pll = 1'b1; push_seq(170, 0, 4);

    // Lock loss and soft request seen in the same cycle: WAIT_LOCK wins.
    wait_edge(335); a_pll = 1'b0;
    wait_edge(337); a_soft = 1'b1; push_a(338, 4'hf, 1'b0, 2'd0);
    wait_edge(338); a_soft = 1'b0;

    // Filter glitch after 5 high cycles; soft request in WAIT_LOCK ignored.
    wait_edge(342); a_pll = 1'b1;
    wait_edge(346); a_soft = 1'b1;
    wait_edge(347); a_soft = 1'b0; a_pll = 1'b0;
    wait_edge(348); a_pll = 1'b1; push_seq(348, 0, 2);

    // Soft request while rst_ch = 1100, then again mid-HOLD to restart the hold count.
    wait_edge(480); a_soft = 1'b1; push_a(481, 4'hf, 1'b0, 2'd1);
    wait_edge(481); a_soft = 1'b0;
    wait_edge(520); a_soft = 1'b1; push_seq(511, 1, 4);
    wait_edge(521); a_soft = 1'b0;

    // Single channel: rst_ch and all_released move together; reset in RUN.
    wait_edge(680); b_reset = 1'b0;
    push_b(690, 1'b1, 1'b0, 2'd1);
    push_b(691, 1'b0, 1'b1, 2'd3);
    wait_edge(695); b_reset = 1'b1; push_b(696, 1'b1, 1'b0, 2'd0);
    wait_edge(696); b_reset = 1'b0;
    push_b(706, 1'b1, 1'b0, 2'd1);
    push_b(707, 1'b0, 1'b1, 2'd3);

    // Re-sequence, then reset mid-RELEASE: no partial release survives.
    wait_edge(700); a_soft = 1'b1;
    push_a(701, 4'hf, 1'b0, 2'd1);
    push_a(801, 4'he, 1'b0, 2'd2);
    wait_edge(701); a_soft = 1'b0;
    wait_edge(805); a_reset = 1'b1; push_a(806, 4'hf, 1'b0, 2'd0);
    wait_edge(808); a_reset = 1'b0; push_seq(808, 0, 0);

    wait_edge(830);
    check("a_pending_expectations", qa.size(), 0);
    check("b_pending_expectations", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
